// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a byte stream into little-endian words and
// writes them to sequential word addresses, holding the CPU until the load ends.
module imem_loader #(
  parameter int WIDTH         = 32,
  parameter int SIZE          = 256,
  parameter int ADDR_W        = $clog2(SIZE),
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  // Handshake: a byte moves on a rising edge where in_valid && in_ready are
  // both high; in_ready is registered and never depends on in_valid.

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_LAST, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] SIZE16 = 16'(SIZE);

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [WIDTH-9:0]    asm_q, asm_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_waddr_q, mem_waddr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     ww_q, ww_d;

  logic                hs;
  logic [15:0]         len16;
  logic [ADDR_W:0]     ww_inc;

  assign hs     = in_valid && in_ready_q;
  assign len16  = {in_data, len_lo_q};
  assign ww_inc = ww_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      len_lo_q    <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= HOLD_AT_RESET;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ww_q        <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      len_lo_q    <= len_lo_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ww_q        <= ww_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    len_lo_d    = len_lo_q;
    count_d     = count_q;
    addr_d      = addr_q;
    in_ready_d  = 1'b0;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = 1'b0;
    err_d       = err_q;
    ww_d        = ww_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          in_ready_d = 1'b1;
          cpu_hold_d = 1'b1;
          err_d      = 1'b0;
          ww_d       = '0;
          byte_cnt_d = '0;
          addr_d     = '0;
        end
      end
      S_LEN: begin
        in_ready_d = 1'b1;
        if (hs) begin
          if (byte_cnt_q == 2'd0) begin
            len_lo_d   = in_data;
            byte_cnt_d = 2'd1;
          end else begin
            byte_cnt_d = 2'd0;
            if (len16 == 16'd0) begin
              state_d    = S_DONE;
              in_ready_d = 1'b0;
              done_d     = 1'b1;
              cpu_hold_d = 1'b0;
            end else if (len16 > SIZE16) begin
              state_d    = S_ERR;
              in_ready_d = 1'b0;
              err_d      = 1'b1;
            end else begin
              state_d = S_DATA;
              count_d = len16[ADDR_W:0];
            end
          end
        end
      end
      S_DATA: begin
        in_ready_d = 1'b1;
        if (hs) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    asm_d[7:0]   = in_data;
            2'd1:    asm_d[15:8]  = in_data;
            2'd2:    asm_d[23:16] = in_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_wdata_d = WIDTH'({in_data, asm_q});
              mem_waddr_d = addr_q;
              addr_d      = addr_q + 1'b1;
              ww_d        = ww_inc;
              // The last word closes the input so no byte lands after it.
              if (ww_inc == count_q) begin
                state_d    = S_LAST;
                in_ready_d = 1'b0;
              end
            end
          endcase
        end
      end
      S_LAST: begin
        state_d    = S_DONE;
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_LAST);
  end

  assign in_ready      = in_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_waddr     = mem_waddr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-level load model checked every cycle,
// a write scoreboard of hand-computed words, and literal spot checks.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  words_written;

  imem_loader #(.WIDTH(32), .SIZE(256), .ADDR_W(8), .HOLD_AT_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err), .words_written(words_written)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: {addr, data} of every write the loads must produce
  logic [39:0] exp_q[$];
  int          we_count  = 0;
  logic [7:0]  last_addr = '0;

  // load model: expectations for the current cycle plus byte-level progress
  bit          m_on = 0;
  bit          loading = 0, tail = 0;
  int          nb = 0, cnt = 0;
  logic [7:0]  lo = '0;
  logic [7:0]  wq[$];
  logic        x_in_ready, x_we, x_hold, x_busy, x_done, x_err;
  logic [7:0]  x_waddr;
  logic [31:0] x_wdata;
  int          x_ww;

  always @(negedge clk) begin
    bit hs;
    bit n_we, n_done;
    if (m_on) begin
      chk("in_ready", 40'(in_ready), 40'(x_in_ready));
      chk("mem_we", 40'(mem_we), 40'(x_we));
      chk("mem_waddr", 40'(mem_waddr), 40'(x_waddr));
      chk("mem_wdata", 40'(mem_wdata), 40'(x_wdata));
      chk("cpu_hold", 40'(cpu_hold), 40'(x_hold));
      chk("busy", 40'(busy), 40'(x_busy));
      chk("done", 40'(done), 40'(x_done));
      chk("err", 40'(err), 40'(x_err));
      chk("words_written", 40'(words_written), 40'(x_ww));
      if (mem_we === 1'b1) begin
        we_count++;
        last_addr = mem_waddr;
        if (exp_q.size() == 0) chk("sb_unexpected_write", {mem_waddr, mem_wdata}, 40'hFF_FFFF_FFFF);
        else chk("sb_write", {mem_waddr, mem_wdata}, exp_q.pop_front());
      end
    end

    hs = (in_valid === 1'b1) && (in_ready === 1'b1);
    n_we = 0;
    n_done = 0;
    if (reset) begin
      loading = 0; tail = 0; wq.delete();
      x_in_ready = 0; x_waddr = '0; x_wdata = '0; x_hold = 1; x_busy = 0;
      x_err = 0; x_ww = 0;
      m_on = 1;
    end else if (tail) begin
      tail = 0; n_done = 1; x_hold = 0; x_busy = 0; x_in_ready = 0;
    end else if (loading) begin
      if (hs) begin
        nb++;
        if (nb == 1) lo = in_data;
        else if (nb == 2) begin
          cnt = {in_data, lo};
          if (cnt == 0) begin
            loading = 0; n_done = 1; x_hold = 0; x_busy = 0; x_in_ready = 0;
          end else if (cnt > 256) begin
            loading = 0; x_err = 1; x_busy = 0; x_in_ready = 0;
          end
        end else begin
          wq.push_back(in_data);
          if (wq.size() == 4) begin
            n_we = 1;
            x_waddr = 8'(x_ww);
            x_wdata = {wq[3], wq[2], wq[1], wq[0]};
            wq.delete();
            x_ww++;
            if (x_ww == cnt) begin
              loading = 0; tail = 1; x_in_ready = 0;
            end
          end
        end
      end
    end else if (start && !x_done) begin
      loading = 1; nb = 0; wq.delete();
      x_hold = 1; x_err = 0; x_ww = 0; x_in_ready = 1; x_busy = 1;
    end
    x_we = n_we;
    x_done = n_done;
  end

  // driver tasks (all start and end at posedge + 1)
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit got = 0;
    if (gap) begin in_valid = 1'b0; step(1); end
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) got = 1;
    end
    step(1);
    in_valid = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_byte: byte %0h not accepted within 50 cycles, required accept", b);
    end
  endtask

  task automatic send_small_image(input bit gap);
    logic [7:0] img[10];
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    exp_q.push_back({8'h00, 32'h0000_0013});
    exp_q.push_back({8'h01, 32'h0010_0093});
    pulse_start();
    chk("start_hold", 40'(cpu_hold), 40'd1);
    for (int i = 0; i < 10; i++) send_byte(img[i], gap);
    chk("last_word_we", 40'(mem_we), 40'd1);
    chk("last_word_ready", 40'(in_ready), 40'd0);
    step(1);
    chk("load_done", 40'(done), 40'd1);
    chk("load_hold_low", 40'(cpu_hold), 40'd0);
    step(1);
    chk("done_pulse_end", 40'(done), 40'd0);
    chk("words_written_2", 40'(words_written), 40'd2);
    chk("sb_drained", 40'(exp_q.size()), 40'd0);
  endtask

  initial begin
    int wc;
    logic [31:0] w;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    step(3);
    reset = 1'b0;
    chk("rst_hold", 40'(cpu_hold), 40'd1);
    chk("rst_ready", 40'(in_ready), 40'd0);
    chk("rst_ww", 40'(words_written), 40'd0);
    chk("rst_done", 40'(done), 40'd0);
    step(2);

    // two-word image, back-to-back bytes then with idle gaps
    wc = we_count;
    send_small_image(1'b0);
    step(2);
    send_small_image(1'b1);
    chk("two_loads_writes", 40'(we_count - wc), 40'd4);
    step(2);

    // zero-length load: done three cycles after start
    wc = we_count;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("len0_done", 40'(done), 40'd1);
    chk("len0_hold", 40'(cpu_hold), 40'd0);
    chk("len0_no_write", 40'(we_count - wc), 40'd0);
    step(2);

    // over-length load, then recovery by a new start
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    step(3);
    chk("ovf_err", 40'(err), 40'd1);
    chk("ovf_ready", 40'(in_ready), 40'd0);
    chk("ovf_hold", 40'(cpu_hold), 40'd1);
    pulse_start();
    chk("ovf_err_clear", 40'(err), 40'd0);
    chk("ovf_restart_ready", 40'(in_ready), 40'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    step(2);

    // full-depth load: 256 words, addresses 0..255
    wc = we_count;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i ^ 8'h5A), 8'(~i), 8'(i + 3)};
      exp_q.push_back({8'(i), w});
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
    end
    step(2);
    chk("full_writes", 40'(we_count - wc), 40'd256);
    chk("full_last_addr", 40'(last_addr), 40'hFF);
    chk("full_ww", 40'(words_written), 40'd256);
    chk("full_hold", 40'(cpu_hold), 40'd0);
    step(2);

    // reset mid-load; a start during DATA is ignored
    wc = we_count;
    exp_q.push_back({8'h00, 32'h4433_2211});
    pulse_start();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    pulse_start();
    chk("busy_after_start", 40'(busy), 40'd1);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    reset = 1'b1;
    step(1);
    chk("mid_rst_we", 40'(mem_we), 40'd0);
    chk("mid_rst_ready", 40'(in_ready), 40'd0);
    chk("mid_rst_busy", 40'(busy), 40'd0);
    chk("mid_rst_ww", 40'(words_written), 40'd0);
    chk("mid_rst_addr", 40'(mem_waddr), 40'd0);
    chk("mid_rst_data", 40'(mem_wdata), 40'd0);
    chk("mid_rst_hold", 40'(cpu_hold), 40'd1);
    step(1);
    reset = 1'b0;
    step(4);
    chk("mid_rst_writes", 40'(we_count - wc), 40'd1);
    chk("final_sb_drained", 40'(exp_q.size()), 40'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
